// File: rtl/api_spi_shifter.sv
// Serial engine for the API chains: shifts 32-bit command words MSB-first on sck/mosi
// (mode 0) while capturing the selected chain's miso reply, framed by a per-chain load strobe.
module api_spi_shifter #(
    parameter int CH_NUM = 2,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        reg_sck,
    input  logic [5:0]        reg_ch_num,
    input  logic [7:0]        reg_word_num,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [WORD_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [WORD_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CH_NUM-1:0] load,
    output logic              sck,
    output logic              mosi,
    input  logic [CH_NUM-1:0] miso,
    output logic [2:0]        dbg_state
);

    localparam int BW = $clog2(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FETCH  = 3'd2,
        S_SHIFT  = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t            state_q;
    logic [7:0]        div_q;
    logic [7:0]        cnt_q;
    logic [7:0]        words_q;
    logic [5:0]        ch_q;
    logic [BW-1:0]     bit_q;
    logic [WORD_W-1:0] tx_sr_q;
    logic [WORD_W-1:0] rx_sr_q;
    logic [WORD_W-1:0] rx_data_q;
    logic              sck_q;
    logic              load_en_q;
    logic              rx_valid_q;
    logic              done_q;
    logic              err_q;
    logic              busy_q;

    logic              miso_bit;
    logic [CH_NUM-1:0] load_vec;
    logic              cnt_hit;
    logic              ch_bad;

    assign cnt_hit = (cnt_q == div_q);
    assign ch_bad  = ({1'b0, reg_ch_num} >= 7'(CH_NUM));

    // Chain select done by compare so an out-of-range latched index selects nothing.
    always_comb begin
        miso_bit = 1'b0;
        load_vec = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (ch_q == 6'(i)) begin
                miso_bit    = miso[i];
                load_vec[i] = load_en_q;
            end
        end
    end

    // Handshake: a word moves when tx_valid & tx_ready are both high at a clk edge;
    // tx_ready is high only in FETCH, which is left on that same edge, so at most one word per FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            words_q    <= '0;
            ch_q       <= '0;
            bit_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            sck_q      <= 1'b0;
            load_en_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            if (abort && (state_q != S_IDLE)) begin
                state_q   <= S_IDLE;
                sck_q     <= 1'b0;
                load_en_q <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                cnt_q     <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            div_q   <= reg_sck;
                            ch_q    <= reg_ch_num;
                            words_q <= reg_word_num;
                            cnt_q   <= '0;
                            if (ch_bad) begin
                                err_q  <= 1'b1;
                                done_q <= 1'b1;
                            end else begin
                                err_q <= 1'b0;
                                if (reg_word_num == 8'd0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    state_q   <= S_LOAD;
                                    busy_q    <= 1'b1;
                                    load_en_q <= 1'b1;
                                end
                            end
                        end
                    end
                    S_LOAD: begin
                        if (cnt_hit) begin
                            cnt_q   <= '0;
                            state_q <= S_FETCH;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    S_FETCH: begin
                        if (tx_valid) begin
                            tx_sr_q <= tx_data;
                            bit_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (!cnt_hit) begin
                            cnt_q <= cnt_q + 8'd1;
                        end else begin
                            cnt_q <= '0;
                            if (!sck_q) begin
                                sck_q   <= 1'b1;
                                rx_sr_q <= {rx_sr_q[WORD_W-2:0], miso_bit};
                            end else begin
                                sck_q   <= 1'b0;
                                tx_sr_q <= {tx_sr_q[WORD_W-2:0], 1'b0};
                                bit_q   <= bit_q + 1'b1;
                                if (bit_q == BW'(WORD_W - 1)) begin
                                    rx_valid_q <= 1'b1;
                                    rx_data_q  <= rx_sr_q;
                                    words_q    <= words_q - 8'd1;
                                    state_q    <= (words_q == 8'd1) ? S_UNLOAD : S_FETCH;
                                end
                            end
                        end
                    end
                    S_UNLOAD: begin
                        if (cnt_hit) begin
                            cnt_q     <= '0;
                            load_en_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign tx_ready  = (state_q == S_FETCH);
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign load      = load_vec;
    assign sck       = sck_q;
    assign mosi      = (state_q == S_SHIFT) & tx_sr_q[WORD_W-1];
    assign dbg_state = state_q;

endmodule
